// File: rtl/mult_sel_seq_resp_if.sv
// Request/response bus for the sequential signed operand-select multiplier.
// The initiator (master) drives four operands, a select and in_valid, and
// consumes the product through out_valid/out_ready. The multiplier is the slave.
interface mult_sel_seq_resp_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0]   a_in;
   logic [WIDTH-1:0]   b_in;
   logic [WIDTH-1:0]   c_in;
   logic [WIDTH-1:0]   d_in;
   logic [3:0]         sel;
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-2:0] y;
   logic               ovf;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output a_in, b_in, c_in, d_in, sel, in_valid, out_ready,
      input  in_ready, y, ovf, out_valid
   );

   modport slave (
      input  a_in, b_in, c_in, d_in, sel, in_valid, out_ready,
      output in_ready, y, ovf, out_valid
   );
endinterface

// File: rtl/mult_sel_seq_resp.sv
// Sequential signed WIDTH x WIDTH multiplier with operand select.
// sel[1:0] picks the multiplicand, sel[3:2] the multiplier (0=a,1=b,2=c,3=d).
// One request at a time: IDLE accepts, BUSY runs WIDTH shift-add steps on the
// operand magnitudes, DONE presents the (2*WIDTH-1)-bit product until taken.
// Optional feature macro: MULT_SEL_SAT_EN -- when defined, the single
// unrepresentable product (-2^(W-1))^2 saturates to 2^(2W-2)-1 and raises ovf;
// when undefined the product wraps and ovf stays 0.
module mult_sel_seq_resp #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_sel_seq_resp_if.slave   bus
);
   localparam int YW = 2*WIDTH-1;        // result width
   localparam int CW = $clog2(WIDTH);    // step counter width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Per-bus operand views: raw value, sign and unsigned magnitude.
   // The magnitude of the most negative value is 2^(W-1), which still fits
   // in WIDTH unsigned bits, so no extra bit is needed here.
   logic [4*WIDTH-1:0] operand_flat;
   logic [WIDTH-1:0]   operand [4];
   logic               op_neg  [4];
   logic [WIDTH-1:0]   op_mag  [4];

   assign operand_flat = {bus.d_in, bus.c_in, bus.b_in, bus.a_in};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_operand
         assign operand[gi] = operand_flat[gi*WIDTH +: WIDTH];
         assign op_neg[gi]  = operand[gi][WIDTH-1];
         assign op_mag[gi]  = op_neg[gi] ? (-operand[gi]) : operand[gi];
      end
   endgenerate

   // Datapath and control state. The magnitude product is at most 2^(2W-2),
   // so a YW-bit unsigned accumulator is sufficient.
   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [YW-1:0]    mcand_reg;
   logic [WIDTH-1:0] mplier_reg;
   logic [YW-1:0]    acc_reg;
   logic             neg_reg;
   logic [YW-1:0]    y_reg;
   logic             ovf_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;

   // Combinational results of the current shift-add step.
   logic [YW-1:0]    acc_next;
   logic [YW-1:0]    y_next;
   logic             ovf_next;
   logic             last_step;
   logic             accept;

   assign last_step = (cnt_reg == CW'(WIDTH-1));
   assign accept    = bus.in_valid && in_ready_reg;

   // One shift-add step, plus sign application and overflow handling that
   // only matter on the final step when the result is registered.
   always_comb begin
      acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
      y_next   = neg_reg ? (-acc_next) : acc_next;
      ovf_next = 1'b0;
`ifdef MULT_SEL_SAT_EN
      // Only +2^(2W-2) sets the top magnitude bit with a positive sign;
      // -2^(2W-2) is representable and passes through unchanged.
      if (!neg_reg && acc_next[YW-1]) begin
         y_next   = {1'b0, {(YW-1){1'b1}}};
         ovf_next = 1'b1;
      end
`endif
   end

   // Control FSM with registered handshake outputs and the datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         acc_reg       <= '0;
         neg_reg       <= 1'b0;
         y_reg         <= '0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               // Latch both selected operands; later bus changes are ignored.
               if (accept) begin
                  mcand_reg    <= YW'(op_mag[bus.sel[1:0]]);
                  mplier_reg   <= op_mag[bus.sel[3:2]];
                  neg_reg      <= op_neg[bus.sel[1:0]] ^ op_neg[bus.sel[3:2]];
                  acc_reg      <= '0;
                  cnt_reg      <= '0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= BUSY;
               end
            end
            BUSY: begin
               // Always WIDTH steps, regardless of operand values.
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + CW'(1);
               if (last_step) begin
                  y_reg         <= y_next;
                  ovf_reg       <= ovf_next;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               // Hold y/ovf until taken; in_ready returns one cycle later.
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.y         = y_reg;
   assign bus.ovf       = ovf_reg;

endmodule
